// File: rtl/noise_tester_pkg.sv
// Shared types and constants for the noise tester display path.
package noise_tester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned BCD_MAX = 9999;

    typedef logic [3:0] bcd_digit_t;

endpackage : noise_tester_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
    import noise_tester_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t adj_c_o
);

    always_comb begin
        adj_c_o = d_i;
        if (d_i >= 4'd5) begin
            adj_c_o = d_i + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Digit outputs only change on the edge that completes a conversion.
module bin_to_bcd_seq
    import noise_tester_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned SCR_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               ovf_cap_q;
    logic               busy_q;
    logic               done_q;
    logic               overflow_q;
    bcd_digit_t         ones_q;
    bcd_digit_t         tens_q;
    bcd_digit_t         hundreds_q;
    bcd_digit_t         thousands_q;

    logic [BCD_W-1:0]   bcd_corr_c;
    logic [SCR_W-1:0]   scratch_shift_c;

    // Per-digit add-3 on the scratch BCD field; no carry between digits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i     (scratch_q[BIN_W + 4*g +: 4]),
            .adj_c_o (bcd_corr_c[4*g +: 4])
        );
    end

    // The top scratch bit falls off; it only matters for inputs that saturate anyway.
    always_comb begin
        scratch_shift_c = SCR_W'({bcd_corr_c, scratch_q[BIN_W-1:0], 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scratch_q   <= '0;
            bit_cnt_q   <= '0;
            ovf_cap_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            ones_q      <= '0;
            tens_q      <= '0;
            hundreds_q  <= '0;
            thousands_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        scratch_q <= {BCD_W'(0), bin_in};
                        bit_cnt_q <= '0;
                        ovf_cap_q <= (bin_in > BIN_W'(BCD_MAX));
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy_q    <= 1'b1;
                    scratch_q <= scratch_shift_c;
                    if (bit_cnt_q == CNT_W'(BIN_W - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= DONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    overflow_q <= ovf_cap_q;
                    // Out-of-range counts saturate to 9999 rather than showing junk digits.
                    if (ovf_cap_q) begin
                        ones_q      <= 4'd9;
                        tens_q      <= 4'd9;
                        hundreds_q  <= 4'd9;
                        thousands_q <= 4'd9;
                    end else begin
                        ones_q      <= scratch_q[BIN_W      +: 4];
                        tens_q      <= scratch_q[BIN_W + 4  +: 4];
                        hundreds_q  <= scratch_q[BIN_W + 8  +: 4];
                        thousands_q <= scratch_q[BIN_W + 12 +: 4];
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign ones      = ones_q;
    assign tens      = tens_q;
    assign hundreds  = hundreds_q;
    assign thousands = thousands_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, corner sequences, random and back-to-back runs.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [3:0]  ones, tens, hundreds, thousands;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: saturate, then split into decimal digits arithmetically.
    function automatic logic [15:0] ref_bcd(input int v);
        int m;
        m = (v > 9999) ? 9999 : v;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] dut_bcd();
        return {thousands, hundreds, tens, ones};
    endfunction

    // Called at a negedge with the DUT idle; returns latency in edges and busy-cycle count.
    task automatic run_conv(input int v, output int lat, output int bcnt, output int both);
        start  = 1'b1;
        bin_in = 14'(v);
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'($urandom);
        lat  = -1;
        bcnt = 0;
        both = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) bcnt++;
            if (busy && done) both++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        vec_t        vecs[7];
        int          lat, bcnt, both, ndone, done_at, base, v;
        logic [15:0] snap;

        vecs[0] = '{1234,  16'h1234, 1'b0};
        vecs[1] = '{0,     16'h0000, 1'b0};
        vecs[2] = '{9999,  16'h9999, 1'b0};
        vecs[3] = '{10000, 16'h9999, 1'b1};
        vecs[4] = '{16383, 16'h9999, 1'b1};
        vecs[5] = '{305,   16'h0305, 1'b0};
        vecs[6] = '{1,     16'h0001, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ovf", 32'(overflow), 0);
        chk("reset_digits", 32'(dut_bcd()), 0);

        // Table vectors, including range boundaries
        foreach (vecs[i]) begin
            run_conv(vecs[i].bin, lat, bcnt, both);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 15);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 14);
            chk($sformatf("vec%0d_busy_with_done", i), 32'(both), 0);
            chk($sformatf("vec%0d_digits", i), 32'(dut_bcd()), 32'(vecs[i].bcd));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("vec%0d_ovf_held", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // Start during busy and bin_in changes after capture are ignored
        start  = 1'b1;
        bin_in = 14'd42;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (c == 5) begin
                start  = 1'b1;
                bin_in = 14'd7777;
            end else if (c == 6) begin
                start  = 1'b0;
                bin_in = 14'd1111;
            end
        end
        chk("ignore_start_ndone", 32'(ndone), 1);
        chk("ignore_start_done_at", 32'(done_at), 15);
        chk("ignore_start_digits", 32'(dut_bcd()), 32'h0042);

        // Reset mid-conversion
        start  = 1'b1;
        bin_in = 14'd5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_digits", 32'(dut_bcd()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", 32'(ndone), 0);
        chk("midreset_digits_after", 32'(dut_bcd()), 0);
        run_conv(305, lat, bcnt, both);
        chk("restart_latency", 32'(lat), 15);
        chk("restart_digits", 32'(dut_bcd()), 32'h0305);

        // Random conversions with random idle gaps
        for (int k = 0; k < 30; k++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            repeat ($urandom_range(0, 3)) begin
                bin_in = 14'($urandom);
                @(negedge clk);
            end
            run_conv(v, lat, bcnt, both);
            chk($sformatf("rand%0d_latency", k), 32'(lat), 15);
            chk($sformatf("rand%0d_digits(v=%0d)", k, v), 32'(dut_bcd()), 32'(ref_bcd(v)));
            chk($sformatf("rand%0d_ovf", k), 32'(overflow), 32'(v > 9999));
        end
        @(negedge clk);

        // Start held high with bin_in incrementing every cycle
        base = int'($urandom_range(9900, 10100));
        snap = ref_bcd(v);
        start  = 1'b1;
        bin_in = 14'(base);
        for (int t = 0; t < 16 * 8; t++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("held_t%0d_done", t), 32'(done), 32'(t % 16 == 15));
            if (t % 16 == 15) begin
                snap = ref_bcd((base + t - 15) & 16383);
                chk($sformatf("held_t%0d_ovf", t), 32'(overflow), 32'(((base + t - 15) & 16383) > 9999));
            end
            chk($sformatf("held_t%0d_digits", t), 32'(dut_bcd()), 32'(snap));
            bin_in = 14'(base + t + 1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_end_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_bin_to_bcd_seq
